mem_io_scheduler: RTL and testbench
===================================

MEM_IO_SCHEDULER -- requirements
Module: mem_io_scheduler

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 10: data-memory address width (matches `DATA_MEM_ADDR_SIZE).
- RX0_BASE, 10'h300: RX0 ring base.
- RX1_BASE, 10'h380: RX1 ring base.
- RX_DEPTH, 16: ring entries per channel, power of two.
- TX0_ADDR, 10'h3FE: TX0 mapped address.
- TX1_ADDR, 10'h3FF: TX1 mapped address.
- STARVE_LIMIT, 8: max RX wait cycles.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- cpuAddr  in  ADDR_W  MEM-stage address.
- cpuRead  in  1  MEM-stage load.
- cpuWrite  in  1  MEM-stage store.
- readyRx0/readyRx1  in  1  byte held by UART RX.
- busyTx0/busyTx1  in  1  UART TX busy.
- memWren  out  1  data-memory write enable.
- memSel  out  2  memory port owner: 00 CPU, 01 RX0, 10 RX1.
- rxAddr  out  ADDR_W  ring write address.
- rxClear0/rxClear1  out  1  RX byte consumed.
- enableTx0/enableTx1  out  1  one-cycle TX start.
- cpuStall  out  1  freeze the pipeline.

Function
REQ-003 FSM states SHALL be IDLE, TX_WAIT and FORCE_RX.
REQ-004 A CPU access is defined as cpuRead|cpuWrite; cpuRead&cpuWrite together SHALL be treated as a write.
REQ-005 In IDLE with a CPU access to a non-TX address: memSel=00, memWren=cpuWrite, no RX grant.
REQ-006 In IDLE with no CPU access (or a TX-address write) and any readyRxN high, an RX grant SHALL occur in the same cycle: memSel=channel, memWren=1, rxAddr=RXn_BASE+headN, rxClearN=1.
REQ-007 When both RX channels are ready, the channel not granted last SHALL win (round-robin); lastGrant updates on each grant.
REQ-008 headN SHALL increment by 1 modulo RX_DEPTH at the edge ending a grant; RX_DEPTH-1 wraps to 0.
REQ-009 Otherwise rxAddr=RX0_BASE+head0.
REQ-010 starveCnt SHALL increment each cycle any readyRxN is high without a grant, and clear on any RX grant.
REQ-011 When starveCnt==STARVE_LIMIT-1 and it would increment, the next state SHALL be FORCE_RX.
REQ-012 FORCE_RX, exactly one cycle: cpuStall=1, RX grant per REQ-006/007 regardless of the CPU access, then IDLE.
REQ-013 A cpuWrite to TXn_ADDR SHALL never assert memWren for the CPU.
REQ-014 If busyTxN=0 and guardN=0, enableTxN=1 in that cycle.
REQ-015 Otherwise cpuStall=1, the FSM enters TX_WAIT, and it latches the channel.
REQ-016 guardN SHALL be set for the one cycle after enableTxN, covering UART busy latency.
REQ-017 TX_WAIT: cpuStall=1 until busyTxN=0 and guardN=0, then enableTxN=1, cpuStall=0, IDLE in the same cycle.
REQ-018 RX grants SHALL remain allowed during TX_WAIT.
REQ-019 enableTx0/enableTx1 SHALL never be high for two consecutive cycles.
REQ-020 A cpuRead of a TX address SHALL be an ordinary memory read.
REQ-021 An RX grant SHALL never occur in the same cycle as a CPU memory write.

Reset
REQ-022 While rst=0 at a clk edge: state=IDLE, head0=head1=0, starveCnt=0, lastGrant=RX1 (so RX0 is served first), guards=0.
REQ-023 While rst=0, all outputs SHALL read 0, except rxAddr=RX0_BASE.
REQ-024 Reset mid-TX_WAIT or mid-FORCE_RX SHALL abort the operation with no enable or clear issued.

Structure
REQ-025 State encodings, memSel codes and default addresses SHALL live in the shared parameters.v.
REQ-026 One sub-module, rx_ring_pointer, SHALL be instantiated per channel, holding the head with wrap-around increment.

Verification
REQ-027 Directed scenarios the bench SHALL cover:
- Idle CPU, readyRx0 pulse with byte 8'h41 -> same cycle memSel=01, rxAddr=10'h300, rxClear0=1; next grant uses 10'h301.
- 17 RX0 grants -> rxAddr sequence 10'h300..10'h30F, then 10'h300.
- readyRx0 and readyRx1 held with CPU idle -> grants alternate RX0, RX1, RX0.
- CPU loads every cycle, readyRx1 high -> cpuStall=1 and an RX1 grant exactly on cycle 9; cpuStall=0 on cycle 10.
- cpuWrite to 10'h3FE with busyTx0=1 for 5 cycles -> cpuStall high for 5 cycles, then one enableTx0 pulse, memWren never 1.
- rst=0 asserted during TX_WAIT -> next cycle all outputs 0, no enableTx0.

Source files
------------

// File: rtl/mem_io_scheduler_pkg.sv
// Shared types and default constants for the memory/UART I/O scheduler.
// FSM encodings, memory-port owner codes and default mapped addresses live here.
package mem_io_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TX_WAIT  = 2'd1,
        ST_FORCE_RX = 2'd2
    } state_t;

    localparam logic [1:0] SEL_CPU = 2'b00;
    localparam logic [1:0] SEL_RX0 = 2'b01;
    localparam logic [1:0] SEL_RX1 = 2'b10;

    localparam int         DEF_ADDR_W       = 10;
    localparam logic [9:0] DEF_RX0_BASE     = 10'h300;
    localparam logic [9:0] DEF_RX1_BASE     = 10'h380;
    localparam int         DEF_RX_DEPTH     = 16;
    localparam logic [9:0] DEF_TX0_ADDR     = 10'h3FE;
    localparam logic [9:0] DEF_TX1_ADDR     = 10'h3FF;
    localparam int         DEF_STARVE_LIMIT = 8;

endpackage

// File: rtl/mem_io_scheduler_rx_ring_pointer.sv
// Head pointer of one RX ring: advances by one on each grant, wrapping at DEPTH.
module rx_ring_pointer #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    output logic [PW-1:0] head
);

    always_ff @(posedge clk) begin
        if (!rst)
            head <= '0;
        else if (adv)
            head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
    end

endmodule

// File: rtl/mem_io_scheduler.sv
// Arbitrates the data-memory port between the CPU MEM stage and two UART RX rings,
// and turns stores to the TX mapped addresses into one-cycle UART TX starts.
module mem_io_scheduler
    import mem_io_scheduler_pkg::*;
#(
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RX0_BASE     = DEF_RX0_BASE,
    parameter logic [ADDR_W-1:0] RX1_BASE     = DEF_RX1_BASE,
    parameter int                RX_DEPTH     = DEF_RX_DEPTH,
    parameter logic [ADDR_W-1:0] TX0_ADDR     = DEF_TX0_ADDR,
    parameter logic [ADDR_W-1:0] TX1_ADDR     = DEF_TX1_ADDR,
    parameter int                STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic              cpuRead,
    input  logic              cpuWrite,
    input  logic              readyRx0,
    input  logic              readyRx1,
    input  logic              busyTx0,
    input  logic              busyTx1,
    output logic              memWren,
    output logic [1:0]        memSel,
    output logic [ADDR_W-1:0] rxAddr,
    output logic              rxClear0,
    output logic              rxClear1,
    output logic              enableTx0,
    output logic              enableTx1,
    output logic              cpuStall
);

    localparam int PW = $clog2(RX_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        state, state_nxt;
    logic          last_grant;   // 0 = RX0, 1 = RX1
    logic          tx_ch;
    logic [1:0]    guard;
    logic [SW-1:0] starve;
    logic [PW-1:0] head0, head1;

    logic cpu_acc, tx_hit0, tx_hit1, any_rdy, rr_ch, grant_ok, grant;
    logic tx_req, tx_ch_cur, tx_free, tx_fire, starve_inc;

    rx_ring_pointer #(.DEPTH(RX_DEPTH), .PW(PW)) u_ptr0 (
        .clk(clk), .rst(rst), .adv(grant && !rr_ch), .head(head0));
    rx_ring_pointer #(.DEPTH(RX_DEPTH), .PW(PW)) u_ptr1 (
        .clk(clk), .rst(rst), .adv(grant && rr_ch), .head(head1));

    // Shared decode used by both the next-state and the output logic.
    always_comb begin
        cpu_acc   = cpuRead | cpuWrite;
        tx_hit0   = cpuWrite && (cpuAddr == TX0_ADDR);
        tx_hit1   = cpuWrite && (cpuAddr == TX1_ADDR);
        any_rdy   = readyRx0 | readyRx1;
        rr_ch     = (readyRx0 && readyRx1) ? ~last_grant : readyRx1;
        case (state)
            ST_IDLE: grant_ok = !cpu_acc || tx_hit0 || tx_hit1;
            default: grant_ok = 1'b1;
        endcase
        grant      = any_rdy && grant_ok;
        tx_req     = (state == ST_TX_WAIT) || (state == ST_IDLE && (tx_hit0 || tx_hit1));
        tx_ch_cur  = (state == ST_TX_WAIT) ? tx_ch : tx_hit1;
        tx_free    = tx_ch_cur ? (!busyTx1 && !guard[1]) : (!busyTx0 && !guard[0]);
        tx_fire    = tx_req && tx_free;
        starve_inc = any_rdy && !grant;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (tx_req && !tx_free)
                    state_nxt = ST_TX_WAIT;
                else if (starve_inc && starve == SW'(STARVE_LIMIT - 1))
                    state_nxt = ST_FORCE_RX;
            end
            ST_TX_WAIT:  if (tx_free) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        memWren   = 1'b0;
        memSel    = SEL_CPU;
        rxAddr    = RX0_BASE;
        rxClear0  = 1'b0;
        rxClear1  = 1'b0;
        enableTx0 = 1'b0;
        enableTx1 = 1'b0;
        cpuStall  = 1'b0;
        if (rst) begin
            memWren   = grant || (state == ST_IDLE && cpuWrite && !tx_hit0 && !tx_hit1);
            memSel    = grant ? (rr_ch ? SEL_RX1 : SEL_RX0) : SEL_CPU;
            rxAddr    = (grant && rr_ch) ? RX1_BASE + ADDR_W'(head1) : RX0_BASE + ADDR_W'(head0);
            rxClear0  = grant && !rr_ch;
            rxClear1  = grant && rr_ch;
            enableTx0 = tx_fire && !tx_ch_cur;
            enableTx1 = tx_fire && tx_ch_cur;
            cpuStall  = (state == ST_FORCE_RX) || (tx_req && !tx_free);
        end
    end

    // Guards block a second start while the UART has not yet raised busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
            tx_ch      <= 1'b0;
            guard      <= 2'b00;
            starve     <= '0;
        end else begin
            guard <= {enableTx1, enableTx0};
            if (grant)
                last_grant <= rr_ch;
            if (state == ST_IDLE && tx_req && !tx_free)
                tx_ch <= tx_hit1;
            if (grant || state == ST_FORCE_RX)
                starve <= '0;
            else if (starve_inc)
                starve <= starve + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_scheduler.sv
// Directed-vector scoreboard bench: the driver queues each cycle's expected outputs,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_mem_io_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] cpuAddr;
    logic       cpuRead, cpuWrite, readyRx0, readyRx1, busyTx0, busyTx1;
    logic       memWren, rxClear0, rxClear1, enableTx0, enableTx1, cpuStall;
    logic [1:0] memSel;
    logic [9:0] rxAddr;

    mem_io_scheduler dut (
        .clk(clk), .rst(rst), .cpuAddr(cpuAddr), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
        .readyRx0(readyRx0), .readyRx1(readyRx1), .busyTx0(busyTx0), .busyTx1(busyTx1),
        .memWren(memWren), .memSel(memSel), .rxAddr(rxAddr), .rxClear0(rxClear0),
        .rxClear1(rxClear1), .enableTx0(enableTx0), .enableTx1(enableTx1), .cpuStall(cpuStall));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    // {memWren, memSel, rxAddr, rxClear0, rxClear1, enableTx0, enableTx1, cpuStall}
    function automatic logic [17:0] ex(input logic w, input logic [1:0] s, input logic [9:0] a,
                                       input logic c0, input logic c1, input logic e0,
                                       input logic e1, input logic st);
        return {w, s, a, c0, c1, e0, e1, st};
    endfunction

    task automatic step(input string name, input logic rs, input logic rd, input logic wr,
                        input logic [9:0] a, input logic r0, input logic r1,
                        input logic b0, input logic b1, input logic [17:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst = rs; cpuRead = rd; cpuWrite = wr; cpuAddr = a;
        readyRx0 = r0; readyRx1 = r1; busyTx0 = b0; busyTx1 = b1;
        x.name = name;
        x.v    = e;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [17:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {memWren, memSel, rxAddr, rxClear0, rxClear1, enableTx0, enableTx1, cpuStall};
                total++;
                if (got === e.v) passed++;
                else $display("FAIL %s: got %h expected %h", e.name, got, e.v);
            end
        end
    end

    localparam logic [17:0] IDLE0 = 18'h0_0000 | (18'h300 << 5);
    localparam logic [17:0] STALL = IDLE0 | 18'h1;

    initial begin : driver
        logic [9:0] a;
        rst = 1'b0; cpuAddr = '0; cpuRead = 0; cpuWrite = 0;
        readyRx0 = 0; readyRx1 = 0; busyTx0 = 0; busyTx1 = 0;

        // Reset: outputs held at zero even with live inputs
        step("reset_idle", 0, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);
        step("reset_busy_inputs", 0, 1, 1, 10'h3FE, 1, 1, 1, 1, IDLE0);

        // Single RX0 byte with idle CPU, then pointer advanced
        step("rx0_grant_300", 1, 0, 0, 10'h000, 1, 0, 0, 0, ex(1, 2'b01, 10'h300, 1, 0, 0, 0, 0));
        step("rx0_idle_301", 1, 0, 0, 10'h000, 0, 0, 0, 0, ex(0, 2'b00, 10'h301, 0, 0, 0, 0, 0));
        step("rx0_grant_301", 1, 0, 0, 10'h000, 1, 0, 0, 0, ex(1, 2'b01, 10'h301, 1, 0, 0, 0, 0));

        // 17 consecutive grants wrap the ring
        step("reset", 0, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);
        for (int i = 0; i < 17; i++) begin
            a = 10'h300 + 10'(i % 16);
            step($sformatf("wrap_grant_%0d", i), 1, 0, 0, 10'h000, 1, 0, 0, 0,
                 ex(1, 2'b01, a, 1, 0, 0, 0, 0));
        end

        // Round robin with both rings ready
        step("reset", 0, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);
        step("rr_rx0_a", 1, 0, 0, 10'h000, 1, 1, 0, 0, ex(1, 2'b01, 10'h300, 1, 0, 0, 0, 0));
        step("rr_rx1_a", 1, 0, 0, 10'h000, 1, 1, 0, 0, ex(1, 2'b10, 10'h380, 0, 1, 0, 0, 0));
        step("rr_rx0_b", 1, 0, 0, 10'h000, 1, 1, 0, 0, ex(1, 2'b01, 10'h301, 1, 0, 0, 0, 0));
        step("rr_rx1_b", 1, 0, 0, 10'h000, 1, 1, 0, 0, ex(1, 2'b10, 10'h381, 0, 1, 0, 0, 0));

        // CPU store blocks RX; read of TX address is a plain read; read+write is a write
        step("cpu_wr_blocks_rx", 1, 0, 1, 10'h020, 1, 0, 0, 0, ex(1, 2'b00, 10'h302, 0, 0, 0, 0, 0));
        step("cpu_rd_tx_addr", 1, 1, 0, 10'h3FE, 0, 0, 0, 0, ex(0, 2'b00, 10'h302, 0, 0, 0, 0, 0));
        step("cpu_rdwr_is_wr", 1, 1, 1, 10'h030, 0, 0, 0, 0, ex(1, 2'b00, 10'h302, 0, 0, 0, 0, 0));

        // Starvation: loads every cycle, RX1 forced on cycle 9
        step("reset", 0, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);
        for (int i = 1; i <= 8; i++)
            step($sformatf("starve_c%0d", i), 1, 1, 0, 10'h010, 0, 1, 0, 0, IDLE0);
        step("starve_c9_force", 1, 1, 0, 10'h010, 0, 1, 0, 0, ex(1, 2'b10, 10'h380, 0, 1, 0, 0, 1));
        step("starve_c10", 1, 1, 0, 10'h010, 0, 1, 0, 0, IDLE0);

        // TX0 busy for 5 cycles, RX1 grant allowed while waiting
        step("reset", 0, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);
        step("tx0_wait_c1", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("tx0_wait_c2", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("tx0_wait_rx1", 1, 0, 1, 10'h3FE, 0, 1, 1, 0, ex(1, 2'b10, 10'h380, 0, 1, 0, 0, 1));
        step("tx0_wait_c4", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("tx0_wait_c5", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("tx0_enable", 1, 0, 1, 10'h3FE, 0, 0, 0, 0, ex(0, 2'b00, 10'h300, 0, 0, 1, 0, 0));
        step("tx0_after", 1, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);

        // TX1 immediate start, then back-to-back store held off by the guard
        step("tx1_immediate", 1, 0, 1, 10'h3FF, 0, 0, 0, 0, ex(0, 2'b00, 10'h300, 0, 0, 0, 1, 0));
        step("tx1_guard_stall", 1, 0, 1, 10'h3FF, 0, 0, 0, 0, STALL);
        step("tx1_guard_enable", 1, 0, 1, 10'h3FF, 0, 0, 0, 0, ex(0, 2'b00, 10'h300, 0, 0, 0, 1, 0));
        step("tx1_after", 1, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);

        // Reset while in TX_WAIT aborts the start
        step("txr_c1", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("txr_c2", 1, 0, 1, 10'h3FE, 0, 0, 1, 0, STALL);
        step("txr_reset", 0, 0, 1, 10'h3FE, 0, 0, 0, 0, IDLE0);
        step("txr_no_enable", 1, 0, 0, 10'h000, 0, 0, 0, 0, IDLE0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d entries pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
